// File: rtl/l1_snoop_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : l1_snoop_responder                                           |
// | Description : Per-core L1 snoop agent. It buffers snoops from the L2       |
// |               coherency controller, looks each one up in the shared L1     |
// |               tag port, and applies the MESI downgrade or invalidate. It   |
// |               returns exactly one response per accepted snoop.             |
// | Options     : L1_SNOOP_FORWARD_CLEAN_EN - read snoops that hit E/S lines   |
// |               also return line data (state transitions are unchanged).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package riscv_mem_types_pkg;
  typedef enum logic [1:0] {
    COHERENCY_REQ_READ        = 2'd0,
    COHERENCY_REQ_READ_UNIQUE = 2'd1,
    COHERENCY_REQ_INVALIDATE  = 2'd2,
    COHERENCY_REQ_WRITEBACK   = 2'd3
  } coherency_req_type_t;
endpackage

module l1_snoop_responder
  import riscv_mem_types_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int L1_WAYS    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       snoop_valid_i,
  input  logic [ADDR_WIDTH-1:0]      snoop_addr_i,
  input  coherency_req_type_t        snoop_type_i,
  output logic                       snoop_rsp_valid_o,
  output logic                       snoop_rsp_data_valid_o,
  output logic [DATA_WIDTH-1:0]      snoop_rsp_data_o,
  output logic                       tag_req_o,
  output logic [ADDR_WIDTH-1:0]      tag_addr_o,
  input  logic                       tag_gnt_i,
  input  logic                       tag_hit_i,
  input  logic [$clog2(L1_WAYS)-1:0] tag_way_i,
  input  logic [1:0]                 tag_state_i,
  input  logic [DATA_WIDTH-1:0]      tag_data_i,
  output logic                       state_wr_en_o,
  output logic [ADDR_WIDTH-1:0]      state_wr_addr_o,
  output logic [$clog2(L1_WAYS)-1:0] state_wr_way_o,
  output logic [1:0]                 state_wr_state_o,
  output logic                       snoop_busy_o,
  output logic                       overflow_o
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int WAY_W = $clog2(L1_WAYS);

  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_S = 2'b01;
  localparam logic [1:0] MESI_M = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_RESOLVE = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_RESPOND = 3'd4
  } state_t;

  // Snoop buffer storage and pointers (extra MSB separates full from empty)
  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic                  fifo_inv_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  fifo_empty, fifo_full, fifo_push, fifo_pop;

  // FSM state, active snoop and registered outputs
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] act_addr_q, act_addr_d;
  logic                  act_inv_q, act_inv_d;
  logic                  tag_req_q, tag_req_d;
  logic                  wr_en_q, wr_en_d;
  logic [WAY_W-1:0]      wr_way_q, wr_way_d;
  logic [1:0]            wr_state_q, wr_state_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_dv_q, rsp_dv_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  overflow_q, overflow_d;
  logic                  line_live, fwd_data;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  // A pop frees the slot the same cycle, so a full buffer still accepts a push
  assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
  assign fifo_push  = snoop_valid_i && (!fifo_full || fifo_pop);

  // Buffer entry write; storage needs no reset since the pointers qualify it
  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      fifo_addr_q[wr_ptr_q[IDX_W-1:0]] <= snoop_addr_i;
      fifo_inv_q[wr_ptr_q[IDX_W-1:0]]  <= (snoop_type_i == COHERENCY_REQ_INVALIDATE);
    end
  end

  // Next-state, protocol action and response computation
  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{(PTR_W-1){1'b0}}, fifo_push};
    rd_ptr_d   = rd_ptr_q + {{(PTR_W-1){1'b0}}, fifo_pop};
    overflow_d = overflow_q | (snoop_valid_i & fifo_full & ~fifo_pop);
    state_d    = state_q;
    act_addr_d = act_addr_q;
    act_inv_d  = act_inv_q;
    wr_way_d   = wr_way_q;
    wr_state_d = wr_state_q;
    rsp_dv_d   = rsp_dv_q;
    rsp_data_d = rsp_data_q;
    line_live  = tag_hit_i && (tag_state_i != MESI_I);
    fwd_data   = (tag_state_i == MESI_M);
`ifdef L1_SNOOP_FORWARD_CLEAN_EN
    fwd_data   = fwd_data || !act_inv_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          act_addr_d = fifo_addr_q[rd_ptr_q[IDX_W-1:0]];
          act_inv_d  = fifo_inv_q[rd_ptr_q[IDX_W-1:0]];
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (tag_gnt_i) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        rsp_dv_d   = line_live && fwd_data;
        rsp_data_d = (line_live && fwd_data) ? tag_data_i : '0;
        if (line_live) begin
          wr_way_d   = tag_way_i;
          wr_state_d = act_inv_q ? MESI_I : MESI_S;
          state_d    = ST_UPDATE;
        end else begin
          state_d    = ST_RESPOND;
        end
      end
      ST_UPDATE: state_d = ST_RESPOND;
      ST_RESPOND: begin
        rsp_dv_d   = 1'b0;
        rsp_data_d = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Strobes are registered from the state being entered
    tag_req_d   = (state_d == ST_LOOKUP);
    wr_en_d     = (state_d == ST_UPDATE);
    rsp_valid_d = (state_d == ST_RESPOND);
  end

  // State and output registers; reset aborts any snoop in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      state_q     <= ST_IDLE;
      act_addr_q  <= '0;
      act_inv_q   <= 1'b0;
      tag_req_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_way_q    <= '0;
      wr_state_q  <= MESI_I;
      rsp_valid_q <= 1'b0;
      rsp_dv_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      act_addr_q  <= act_addr_d;
      act_inv_q   <= act_inv_d;
      tag_req_q   <= tag_req_d;
      wr_en_q     <= wr_en_d;
      wr_way_q    <= wr_way_d;
      wr_state_q  <= wr_state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dv_q    <= rsp_dv_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign snoop_rsp_valid_o      = rsp_valid_q;
  assign snoop_rsp_data_valid_o = rsp_dv_q;
  assign snoop_rsp_data_o       = rsp_data_q;
  assign tag_req_o              = tag_req_q;
  assign tag_addr_o             = act_addr_q;
  assign state_wr_en_o          = wr_en_q;
  assign state_wr_addr_o        = act_addr_q;
  assign state_wr_way_o         = wr_way_q;
  assign state_wr_state_o       = wr_state_q;
  assign snoop_busy_o           = !fifo_empty || (state_q != ST_IDLE);
  assign overflow_o             = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_l1_snoop_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_l1_snoop_responder                                        |
// | Description : Directed self-checking bench for l1_snoop_responder with a   |
// |               small address-keyed L1 tag model and a controllable grant.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_l1_snoop_responder;
  import riscv_mem_types_pkg::*;

  logic                clk = 1'b0;
  logic                rst_i;
  logic                snoop_valid_i;
  logic [31:0]         snoop_addr_i;
  coherency_req_type_t snoop_type_i;
  logic                snoop_rsp_valid_o, snoop_rsp_data_valid_o;
  logic [31:0]         snoop_rsp_data_o;
  logic                tag_req_o;
  logic [31:0]         tag_addr_o;
  logic                tag_gnt_i, tag_hit_i;
  logic [1:0]          tag_way_i, tag_state_i;
  logic [31:0]         tag_data_i;
  logic                state_wr_en_o;
  logic [31:0]         state_wr_addr_o;
  logic [1:0]          state_wr_way_o, state_wr_state_o;
  logic                snoop_busy_o, overflow_o;
  logic                gnt_en;

  int n_vec = 0;
  int n_miscompare = 0;

`ifdef L1_SNOOP_FORWARD_CLEAN_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  always #5 clk = ~clk;

  l1_snoop_responder dut (
    .clk_i                  (clk),
    .rst_i                  (rst_i),
    .snoop_valid_i          (snoop_valid_i),
    .snoop_addr_i           (snoop_addr_i),
    .snoop_type_i           (snoop_type_i),
    .snoop_rsp_valid_o      (snoop_rsp_valid_o),
    .snoop_rsp_data_valid_o (snoop_rsp_data_valid_o),
    .snoop_rsp_data_o       (snoop_rsp_data_o),
    .tag_req_o              (tag_req_o),
    .tag_addr_o             (tag_addr_o),
    .tag_gnt_i              (tag_gnt_i),
    .tag_hit_i              (tag_hit_i),
    .tag_way_i              (tag_way_i),
    .tag_state_i            (tag_state_i),
    .tag_data_i             (tag_data_i),
    .state_wr_en_o          (state_wr_en_o),
    .state_wr_addr_o        (state_wr_addr_o),
    .state_wr_way_o         (state_wr_way_o),
    .state_wr_state_o       (state_wr_state_o),
    .snoop_busy_o           (snoop_busy_o),
    .overflow_o             (overflow_o)
  );

  assign tag_gnt_i = tag_req_o & gnt_en;

  // L1 tag array model keyed on the lookup address
  always_comb begin
    tag_hit_i   = 1'b0;
    tag_way_i   = 2'd0;
    tag_state_i = 2'b00;
    tag_data_i  = 32'h0;
    case (tag_addr_o)
      32'h1000: begin tag_hit_i = 1'b1; tag_way_i = 2'd2; tag_state_i = 2'b11; tag_data_i = 32'hDEADBEEF; end
      32'h2000: begin tag_hit_i = 1'b1; tag_way_i = 2'd1; tag_state_i = 2'b01; tag_data_i = 32'h12345678; end
      32'h4000: begin tag_hit_i = 1'b1; tag_way_i = 2'd3; tag_state_i = 2'b10; tag_data_i = 32'hCAFEF00D; end
      32'h5000: begin tag_hit_i = 1'b1; tag_way_i = 2'd0; tag_state_i = 2'b00; tag_data_i = 32'h55AA55AA; end
      default: begin
        if (tag_addr_o[31:12] == 20'h00008) begin
          tag_hit_i   = 1'b1;
          tag_way_i   = tag_addr_o[5:4];
          tag_state_i = 2'b11;
          tag_data_i  = 32'hA0000000 | tag_addr_o;
        end
      end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one snoop from idle, trace it cycle by cycle, then check the trace
  task automatic run_snoop(input string tag, input logic [31:0] addr, input logic inv,
                           input int stall, input logic exp_wr, input logic [1:0] exp_st,
                           input logic [1:0] exp_way, input logic exp_dv,
                           input logic [31:0] exp_data);
    int         wr_cyc, rsp_cyc, n_rsp, n_wr, n_req, stall_left;
    logic [1:0] got_st, got_way;
    logic [31:0] got_waddr, got_data;
    logic       got_dv;
    wr_cyc = -1; rsp_cyc = -1; n_rsp = 0; n_wr = 0; n_req = 0;
    got_st = 2'b00; got_way = 2'd0; got_waddr = 32'h0; got_data = 32'h0; got_dv = 1'b0;
    stall_left = stall;
    tick();
    snoop_valid_i = 1'b1;
    snoop_addr_i  = addr;
    snoop_type_i  = inv ? COHERENCY_REQ_INVALIDATE : COHERENCY_REQ_READ;
    gnt_en        = (stall == 0);
    for (int c = 1; c <= 12 + stall; c++) begin
      tick();
      snoop_valid_i = 1'b0;
      if (tag_req_o) begin
        n_req++;
        if (stall_left > 0) begin
          stall_left--;
          gnt_en = 1'b0;
        end else begin
          gnt_en = 1'b1;
        end
      end
      if (state_wr_en_o) begin
        n_wr++; wr_cyc = c;
        got_st = state_wr_state_o; got_way = state_wr_way_o; got_waddr = state_wr_addr_o;
      end
      if (snoop_rsp_valid_o) begin
        n_rsp++; rsp_cyc = c;
        got_dv = snoop_rsp_data_valid_o; got_data = snoop_rsp_data_o;
      end
    end
    gnt_en = 1'b1;
    check({tag, ".n_rsp"},    64'(n_rsp), 64'd1);
    check({tag, ".rsp_cyc"},  64'(rsp_cyc), 64'((exp_wr ? 5 : 4) + stall));
    check({tag, ".data_vld"}, 64'(got_dv), 64'(exp_dv));
    check({tag, ".data"},     64'(got_data), 64'(exp_data));
    check({tag, ".n_wr"},     64'(n_wr), 64'(exp_wr));
    check({tag, ".n_req"},    64'(n_req), 64'(1 + stall));
    if (exp_wr) begin
      check({tag, ".wr_cyc"},   64'(wr_cyc), 64'(4 + stall));
      check({tag, ".wr_state"}, 64'(got_st), 64'(exp_st));
      check({tag, ".wr_way"},   64'(got_way), 64'(exp_way));
      check({tag, ".wr_addr"},  64'(got_waddr), 64'(addr));
    end
    check({tag, ".idle_busy"}, 64'(snoop_busy_o), 64'd0);
  endtask

  initial begin
    logic [31:0] rsp_data [8];
    int          n_rsp;
    rst_i = 1'b1; snoop_valid_i = 1'b0; snoop_addr_i = 32'h0;
    snoop_type_i = COHERENCY_REQ_READ; gnt_en = 1'b1;
    tick(); tick();
    check("reset.rsp_valid", 64'(snoop_rsp_valid_o), 64'd0);
    check("reset.tag_req",   64'(tag_req_o), 64'd0);
    check("reset.wr_en",     64'(state_wr_en_o), 64'd0);
    check("reset.busy",      64'(snoop_busy_o), 64'd0);
    check("reset.overflow",  64'(overflow_o), 64'd0);
    rst_i = 1'b0;

    //                        addr      inv  stall wr    st     way   dv            data
    run_snoop("rd_m",       32'h1000, 1'b0, 0, 1'b1, 2'b01, 2'd2, 1'b1,         32'hDEADBEEF);
    run_snoop("inv_s",      32'h2000, 1'b1, 0, 1'b1, 2'b00, 2'd1, 1'b0,         32'h0);
    run_snoop("rd_miss",    32'h3000, 1'b0, 0, 1'b0, 2'b00, 2'd0, 1'b0,         32'h0);
    run_snoop("rd_m_stall", 32'h1000, 1'b0, 3, 1'b1, 2'b01, 2'd2, 1'b1,         32'hDEADBEEF);
    run_snoop("rd_e",       32'h4000, 1'b0, 0, 1'b1, 2'b01, 2'd3, FWD,          FWD ? 32'hCAFEF00D : 32'h0);
    run_snoop("inv_e",      32'h4000, 1'b1, 0, 1'b1, 2'b00, 2'd3, 1'b0,         32'h0);
    run_snoop("inv_m",      32'h1000, 1'b1, 0, 1'b1, 2'b00, 2'd2, 1'b1,         32'hDEADBEEF);
    run_snoop("rd_hit_i",   32'h5000, 1'b0, 0, 1'b0, 2'b00, 2'd0, 1'b0,         32'h0);
    run_snoop("rd_s",       32'h2000, 1'b0, 0, 1'b1, 2'b01, 2'd1, FWD,          FWD ? 32'h12345678 : 32'h0);

    // Overflow: a primer snoop parks the FSM in LOOKUP, then six back-to-back
    // snoops arrive; four fill the buffer and the last two are dropped.
    gnt_en = 1'b0;
    tick();
    snoop_valid_i = 1'b1; snoop_addr_i = 32'h8000; snoop_type_i = COHERENCY_REQ_READ;
    tick(); snoop_valid_i = 1'b0;
    tick(); tick();
    check("ovf.primer_req", 64'(tag_req_o), 64'd1);
    for (int k = 1; k <= 6; k++) begin
      snoop_valid_i = 1'b1;
      snoop_addr_i  = 32'h8000 + 32'(k * 16);
      tick();
      if (k == 4) check("ovf.full_no_flag", 64'(overflow_o), 64'd0);
      if (k == 5) check("ovf.flag_set",     64'(overflow_o), 64'd1);
    end
    snoop_valid_i = 1'b0;
    check("ovf.busy", 64'(snoop_busy_o), 64'd1);
    gnt_en = 1'b1;
    n_rsp = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (snoop_rsp_valid_o) begin
        if (n_rsp < 8) rsp_data[n_rsp] = snoop_rsp_data_o;
        n_rsp++;
      end
    end
    check("ovf.n_rsp", 64'(n_rsp), 64'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("ovf.order%0d", i), 64'(rsp_data[i]), 64'(32'hA0008000 + 32'(i * 16)));
    check("ovf.sticky", 64'(overflow_o), 64'd1);
    check("ovf.drained_busy", 64'(snoop_busy_o), 64'd0);

    // Reset while the state write is in progress
    tick();
    snoop_valid_i = 1'b1; snoop_addr_i = 32'h1000; snoop_type_i = COHERENCY_REQ_READ;
    tick(); snoop_valid_i = 1'b0;
    tick(); tick(); tick();
    check("rst_mid.in_update", 64'(state_wr_en_o), 64'd1);
    rst_i = 1'b1;
    #1;
    check("rst_mid.wr_en",    64'(state_wr_en_o), 64'd0);
    check("rst_mid.wr_addr",  64'(state_wr_addr_o), 64'd0);
    check("rst_mid.wr_wstat", 64'({state_wr_way_o, state_wr_state_o}), 64'd0);
    check("rst_mid.rsp",      64'({snoop_rsp_valid_o, snoop_rsp_data_valid_o}), 64'd0);
    check("rst_mid.rsp_data", 64'(snoop_rsp_data_o), 64'd0);
    check("rst_mid.tag",      64'({tag_req_o, tag_addr_o}), 64'd0);
    check("rst_mid.flags",    64'({snoop_busy_o, overflow_o}), 64'd0);
    tick(); tick();
    rst_i = 1'b0;
    n_rsp = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (snoop_rsp_valid_o) n_rsp++;
    end
    check("rst_mid.no_rsp", 64'(n_rsp), 64'd0);
    check("rst_mid.idle",   64'(snoop_busy_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
`default_nettype wire
